ysyx_210544_csr_ctrl: RTL and testbench
=======================================

// Module: ysyx_210544_csr_ctrl
// PURPOSE
//  Initiator side of the CSR port: drives the CSR file's ren/addr/wen/wdata/rdata interface.
//  Executes Zicsr read-modify-write ops, ECALL trap entry, MRET return and M-timer interrupt entry.
//  Each multi-CSR sequence runs as one access per cycle, in order.
//  Sits between the execute stage and the CSR file; produces the rd value and PC redirects.
// PARAMETERS
//  ADR_MSTATUS  12'h300  mstatus address
//  ADR_MTVEC    12'h305  mtvec address
//  ADR_MEPC     12'h341  mepc address
//  ADR_MCAUSE   12'h342  mcause address
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous active-high reset
//  i_req_valid     in   1   request valid
//  o_req_ready     out  1   1 only in IDLE with no timer interrupt pending
//  i_req_op        in   4   0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET; other codes are NOP
//  i_req_csr_addr  in   12  target CSR for ops 0-2
//  i_req_src       in   64  rs1 value, or zero-extended zimm for the I-variants
//  i_req_pc        in   64  PC of the requesting instruction
//  i_intr_pc       in   64  PC to save as mepc on interrupt entry
//  i_mtip          in   1   timer pending from CLINT
//  i_mstatus_mie   in   1   mstatus.MIE from the CSR file
//  i_mie_mtie      in   1   mie.MTIE from the CSR file
//  o_csr_ren       out  1   CSR read enable
//  o_csr_addr      out  12  CSR address
//  o_csr_wen       out  1   CSR write enable
//  o_csr_wdata     out  64  CSR write data
//  i_csr_rdata     in   64  CSR read data, combinational, same cycle
//  o_rsp_valid     out  1   1-cycle pulse when an accepted request completes
//  o_rsp_rdata     out  64  old CSR value for ops 0-2, else 0
//  o_redirect_valid out 1   1-cycle pulse; fetch restarts at o_redirect_pc
//  o_redirect_pc   out  64  redirect target
// BEHAVIOUR
//  Reset:
//   - State goes to IDLE and all outputs are 0, except o_req_ready, which is 1 when not pending.
//   - Latched op, addr, src and pc are cleared.
//   - Reset mid-sequence aborts it: no further CSR writes and no rsp or redirect pulse.
//  Interrupt:
//   - pend = i_mtip & i_mstatus_mie & i_mie_mtie.
//   - In IDLE, pend has priority over any request: ready=0, and the next state is T_EPC (cause 64'h8000_0000_0000_0007, epc = i_intr_pc).
//  Request accept:
//   - Accept on the edge where valid & ready; latch op, addr, src and pc.
//   - Call that cycle 0. Next state: CSR (ops 0-2), T_EPC (op 3, cause 64'd11, epc = pc), M_ST (op 4), NOP (other codes).
//  State outputs (CSR port signals are combinational from state + latched data + i_csr_rdata):
//   - CSR:
//     - ren=1, addr=latched, rsp_valid=1, rsp_rdata=i_csr_rdata.
//     - wdata: RW src; RS rdata|src; RC rdata&~src.
//     - wen=1 except RS/RC with src==0 (no write). Next state IDLE.
//   - T_EPC: wen mepc <= {epc[63:2],2'b00}. Next state T_CAUSE.
//   - T_CAUSE: wen mcause <= cause. Next state T_ST.
//   - T_ST: ren+wen mstatus; wdata = rdata with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11. Next state T_VEC.
//   - T_VEC:
//     - ren mtvec; redirect_valid=1, redirect_pc={rdata[63:2],2'b00} (direct mode only).
//     - rsp_valid=1 for ECALL; no rsp for an interrupt. Next state IDLE.
//   - M_ST: ren+wen mstatus; wdata = rdata with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11. Next state M_EPC.
//   - M_EPC: ren mepc; redirect_valid=1, redirect_pc=rdata, rsp_valid=1. Next state IDLE.
//   - NOP: rsp_valid=1, rsp_rdata=0, no CSR access. Next state IDLE.
//  Latency and back-to-back:
//   - Completion cycle: CSR ops and NOP cycle 1; MRET cycle 2; ECALL and interrupt cycle 4.
//   - Ready returns in the cycle after completion. No CSR access in IDLE.
//   - pend is sampled only in IDLE; MIE cleared in T_ST blocks re-entry.
//  Width rules: all data paths are 64-bit; no truncation except the forced 2'b00 in epc and mtvec alignment.
// TESTING
//  1. CSRRW mscratch (0x340) src=0xDEAD, old 0x5:
//     cycle 1 wen=1 wdata=0xDEAD, rsp_rdata=0x5; ready high again in cycle 2.
//  2. CSRRS mstatus src=0, mstatus=0x1800:
//     rsp_rdata=0x1800, wen=0 all cycles. CSRRC with src=0x8 on mstatus 0x1808 writes 0x1800.
//  3. ECALL pc=0x8000_0010, mstatus=0x1808, mtvec=0x8000_0101:
//     writes mepc=0x8000_0010, mcause=11, mstatus=0x1880.
//     Cycle 4: redirect_pc=0x8000_0100 with rsp_valid.
//  4. MRET, mstatus=0x1880, mepc=0x8000_0014:
//     cycle 1 writes mstatus=0x1888; cycle 2 redirect_pc=0x8000_0014, rsp_valid.
//  5. mtip=mie=mtie=1 with i_req_valid=1:
//     ready=0, request not accepted; mcause=0x8000_0000_0000_0007, mepc=i_intr_pc.
//     No rsp; request accepted after return to IDLE.
//  6. rst asserted in T_CAUSE of an ECALL:
//     next cycle IDLE, no mstatus write, no redirect; mepc keeps the value written in T_EPC.

Source files
------------

// File: rtl/ysyx_210544_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_210544_csr_ctrl
// Brief   : CSR access initiator. Executes Zicsr read-modify-write ops,
//           ECALL trap entry, MRET return and machine-timer interrupt entry,
//           one CSR access per cycle, and returns rd values / PC redirects.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_210544_csr_ctrl #(
  parameter logic [11:0] ADR_MSTATUS = 12'h300,
  parameter logic [11:0] ADR_MTVEC   = 12'h305,
  parameter logic [11:0] ADR_MEPC    = 12'h341,
  parameter logic [11:0] ADR_MCAUSE  = 12'h342
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [11:0] i_req_csr_addr,
  input  logic [63:0] i_req_src,
  input  logic [63:0] i_req_pc,
  input  logic [63:0] i_intr_pc,
  input  logic        i_mtip,
  input  logic        i_mstatus_mie,
  input  logic        i_mie_mtie,
  output logic        o_csr_ren,
  output logic [11:0] o_csr_addr,
  output logic        o_csr_wen,
  output logic [63:0] o_csr_wdata,
  input  logic [63:0] i_csr_rdata,
  output logic        o_rsp_valid,
  output logic [63:0] o_rsp_rdata,
  output logic        o_redirect_valid,
  output logic [63:0] o_redirect_pc
);

  localparam logic [3:0]  OP_CSRRW = 4'd0;
  localparam logic [3:0]  OP_CSRRS = 4'd1;
  localparam logic [3:0]  OP_CSRRC = 4'd2;
  localparam logic [3:0]  OP_ECALL = 4'd3;
  localparam logic [3:0]  OP_MRET  = 4'd4;
  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CSR     = 4'd1,
    S_T_EPC   = 4'd2,
    S_T_CAUSE = 4'd3,
    S_T_ST    = 4'd4,
    S_T_VEC   = 4'd5,
    S_M_ST    = 4'd6,
    S_M_EPC   = 4'd7,
    S_NOP     = 4'd8
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  op_q;
  logic [11:0] addr_q;
  logic [63:0] src_q;
  logic [63:0] pc_q;      // request PC, or interrupt PC on interrupt entry
  logic        intr_q;    // current trap sequence is an interrupt, not ECALL

  logic        pend;
  logic        accept;
  logic [63:0] cause;

  assign pend        = i_mtip & i_mstatus_mie & i_mie_mtie;
  assign o_req_ready = (state == S_IDLE) & ~pend;
  assign accept      = i_req_valid & o_req_ready;
  assign cause       = intr_q ? CAUSE_MTI : CAUSE_ECALL_M;

  // State register and request/trap context capture, only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= 4'd0;
      addr_q <= 12'd0;
      src_q  <= 64'd0;
      pc_q   <= 64'd0;
      intr_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IDLE) begin
        if (pend) begin
          intr_q <= 1'b1;
          pc_q   <= i_intr_pc;
        end else if (accept) begin
          intr_q <= 1'b0;
          op_q   <= i_req_op;
          addr_q <= i_req_csr_addr;
          src_q  <= i_req_src;
          pc_q   <= i_req_pc;
        end
      end
    end
  end

  // Next-state and per-state CSR port / response / redirect outputs
  always_comb begin
    next_state       = state;
    o_csr_ren        = 1'b0;
    o_csr_addr       = 12'd0;
    o_csr_wen        = 1'b0;
    o_csr_wdata      = 64'd0;
    o_rsp_valid      = 1'b0;
    o_rsp_rdata      = 64'd0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = 64'd0;

    case (state)
      S_IDLE: begin
        if (pend) begin
          next_state = S_T_EPC;
        end else if (i_req_valid) begin
          case (i_req_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: next_state = S_CSR;
            OP_ECALL:                     next_state = S_T_EPC;
            OP_MRET:                      next_state = S_M_ST;
            default:                      next_state = S_NOP;
          endcase
        end
      end
      S_CSR: begin
        o_csr_ren   = 1'b1;
        o_csr_addr  = addr_q;
        o_rsp_valid = 1'b1;
        o_rsp_rdata = i_csr_rdata;
        case (op_q)
          OP_CSRRW: o_csr_wdata = src_q;
          OP_CSRRS: o_csr_wdata = i_csr_rdata | src_q;
          default:  o_csr_wdata = i_csr_rdata & ~src_q;
        endcase
        // set/clear with a zero mask must not write (read-only CSRs)
        o_csr_wen  = (op_q == OP_CSRRW) | (src_q != 64'd0);
        next_state = S_IDLE;
      end
      S_T_EPC: begin
        o_csr_wen   = 1'b1;
        o_csr_addr  = ADR_MEPC;
        o_csr_wdata = {pc_q[63:2], 2'b00};
        next_state  = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        o_csr_wen   = 1'b1;
        o_csr_addr  = ADR_MCAUSE;
        o_csr_wdata = cause;
        next_state  = S_T_ST;
      end
      S_T_ST: begin
        o_csr_ren          = 1'b1;
        o_csr_wen          = 1'b1;
        o_csr_addr         = ADR_MSTATUS;
        o_csr_wdata        = i_csr_rdata;
        o_csr_wdata[7]     = i_csr_rdata[3];
        o_csr_wdata[3]     = 1'b0;
        o_csr_wdata[12:11] = 2'b11;
        next_state         = S_T_VEC;
      end
      S_T_VEC: begin
        o_csr_ren        = 1'b1;
        o_csr_addr       = ADR_MTVEC;
        o_redirect_valid = 1'b1;
        o_redirect_pc    = {i_csr_rdata[63:2], 2'b00};
        o_rsp_valid      = ~intr_q;
        next_state       = S_IDLE;
      end
      S_M_ST: begin
        o_csr_ren          = 1'b1;
        o_csr_wen          = 1'b1;
        o_csr_addr         = ADR_MSTATUS;
        o_csr_wdata        = i_csr_rdata;
        o_csr_wdata[3]     = i_csr_rdata[7];
        o_csr_wdata[7]     = 1'b1;
        o_csr_wdata[12:11] = 2'b11;
        next_state         = S_M_EPC;
      end
      S_M_EPC: begin
        o_csr_ren        = 1'b1;
        o_csr_addr       = ADR_MEPC;
        o_redirect_valid = 1'b1;
        o_redirect_pc    = i_csr_rdata;
        o_rsp_valid      = 1'b1;
        next_state       = S_IDLE;
      end
      S_NOP: begin
        o_rsp_valid = 1'b1;
        next_state  = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase

    // a reset landing mid-sequence must not let the current step write or pulse
    if (rst) begin
      o_csr_ren        = 1'b0;
      o_csr_addr       = 12'd0;
      o_csr_wen        = 1'b0;
      o_csr_wdata      = 64'd0;
      o_rsp_valid      = 1'b0;
      o_rsp_rdata      = 64'd0;
      o_redirect_valid = 1'b0;
      o_redirect_pc    = 64'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_210544_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_210544_csr_ctrl
// Brief   : Self-checking bench for ysyx_210544_csr_ctrl with a CSR file
//           model and a transaction-level reference of the architectural
//           effect of each op.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_210544_csr_ctrl;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [11:0] req_addr = 12'd0;
  logic [63:0] req_src = 64'd0;
  logic [63:0] req_pc = 64'd0;
  logic [63:0] intr_pc = 64'd0;
  logic        mtip = 1'b0;
  logic        mtie = 1'b0;
  logic        mstatus_mie;
  logic        csr_ren, csr_wen, rsp_valid, rdr_valid;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata, rsp_rdata, rdr_pc;

  int compared = 0;
  int mismatched = 0;

  // CSR file environment model and architectural reference
  logic [63:0] csrf [4096];
  logic [63:0] ref_csr [logic [11:0]];
  logic [11:0] alist [5] = '{A_MSCRATCH, A_MSTATUS, A_MTVEC, A_MEPC, A_MCAUSE};

  always #5 clk = ~clk;

  // CSR file: writes land at the clock edge, reads are combinational
  always @(posedge clk) if (csr_wen) csrf[csr_addr] <= csr_wdata;
  assign csr_rdata   = csr_ren ? csrf[csr_addr] : 64'd0;
  assign mstatus_mie = csrf[12'h300][3];

  ysyx_210544_csr_ctrl dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_csr_addr(req_addr), .i_req_src(req_src), .i_req_pc(req_pc),
    .i_intr_pc(intr_pc), .i_mtip(mtip), .i_mstatus_mie(mstatus_mie),
    .i_mie_mtie(mtie),
    .o_csr_ren(csr_ren), .o_csr_addr(csr_addr), .o_csr_wen(csr_wen),
    .o_csr_wdata(csr_wdata), .i_csr_rdata(csr_rdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
    .o_redirect_valid(rdr_valid), .o_redirect_pc(rdr_pc)
  );

  function automatic logic [63:0] ecall_ms(input logic [63:0] ms);
    return (ms & ~64'h1888) | 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
  endfunction

  function automatic logic [63:0] mret_ms(input logic [63:0] ms);
    return (ms & ~64'h1888) | 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one request, observe it to completion and compare against reference
  task automatic do_req(input logic [3:0] op, input logic [11:0] addr,
                        input logic [63:0] src, input logic [63:0] pc);
    int exp_lat, exp_wr, n, rsp_cyc, rsp_cnt, rdr_cnt, rdy_cyc, wr_cnt;
    logic exp_rdr, chk_rd;
    logic [63:0] exp_rd, exp_pc, old, got_rd, got_pc;
    exp_rdr = 1'b0; exp_pc = 64'd0; exp_rd = 64'd0; chk_rd = 1'b1; exp_wr = 0;
    if (op <= 4'd2) begin
      exp_lat = 1;
      chk_rd  = ref_csr.exists(addr);
      old     = chk_rd ? ref_csr[addr] : 64'd0;
      exp_rd  = old;
      if (op == 4'd0) begin
        exp_wr = 1; ref_csr[addr] = src;
      end else if (src != 64'd0) begin
        exp_wr = 1;
        if (chk_rd) ref_csr[addr] = (op == 4'd1) ? (old | src) : (old & ~src);
      end
    end else if (op == 4'd3) begin
      exp_lat = 4; exp_wr = 3; exp_rdr = 1'b1;
      exp_pc = ref_csr[A_MTVEC] & ~64'h3;
      ref_csr[A_MEPC]    = pc & ~64'h3;
      ref_csr[A_MCAUSE]  = 64'd11;
      ref_csr[A_MSTATUS] = ecall_ms(ref_csr[A_MSTATUS]);
    end else if (op == 4'd4) begin
      exp_lat = 2; exp_wr = 1; exp_rdr = 1'b1;
      exp_pc = ref_csr[A_MEPC];
      ref_csr[A_MSTATUS] = mret_ms(ref_csr[A_MSTATUS]);
    end else begin
      exp_lat = 1;
    end

    req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src; req_pc = pc;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin step(); #1; n++; end
    if (!req_ready) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout op=%0d: ready stayed 0, want 1", op);
      req_valid = 1'b0;
      return;
    end
    step();
    req_valid = 1'b0; req_op = 4'($urandom); req_addr = 12'($urandom);
    req_src = {$urandom, $urandom}; req_pc = {$urandom, $urandom};
    #1;
    rsp_cyc = 0; rsp_cnt = 0; rdr_cnt = 0; rdy_cyc = 0; wr_cnt = 0;
    got_rd = 64'd0; got_pc = 64'd0;
    for (int c = 1; c <= 8; c++) begin
      if (csr_wen) wr_cnt++;
      if (rsp_valid) begin rsp_cnt++; rsp_cyc = c; got_rd = rsp_rdata; end
      if (rdr_valid) begin rdr_cnt++; got_pc = rdr_pc; end
      if (req_ready) begin rdy_cyc = c; break; end
      step(); #1;
    end

    compared++;
    if (rsp_cnt !== 1 || rsp_cyc !== exp_lat) begin
      mismatched++;
      $display("FAIL rsp_timing op=%0d: got %0d pulses at cycle %0d, want 1 at cycle %0d",
               op, rsp_cnt, rsp_cyc, exp_lat);
    end
    compared++;
    if (rdy_cyc !== exp_lat + 1) begin
      mismatched++;
      $display("FAIL ready_return op=%0d: got cycle %0d, want %0d", op, rdy_cyc, exp_lat + 1);
    end
    if (chk_rd) begin
      compared++;
      if (got_rd !== exp_rd) begin
        mismatched++;
        $display("FAIL rsp_rdata op=%0d: got %h, want %h", op, got_rd, exp_rd);
      end
    end
    compared++;
    if (rdr_cnt !== (exp_rdr ? 1 : 0) || (exp_rdr && got_pc !== exp_pc)) begin
      mismatched++;
      $display("FAIL redirect op=%0d: got %0d pulses pc %h, want %0d pc %h",
               op, rdr_cnt, got_pc, exp_rdr ? 1 : 0, exp_pc);
    end
    compared++;
    if (wr_cnt !== exp_wr) begin
      mismatched++;
      $display("FAIL write_count op=%0d: got %0d, want %0d", op, wr_cnt, exp_wr);
    end
    foreach (alist[i]) begin
      if (ref_csr.exists(alist[i])) begin
        compared++;
        if (csrf[alist[i]] !== ref_csr[alist[i]]) begin
          mismatched++;
          $display("FAIL csr_state %h after op=%0d: got %h, want %h",
                   alist[i], op, csrf[alist[i]], ref_csr[alist[i]]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b, want 1", req_ready);
    end
    compared++;
    if ({csr_ren, csr_wen, csr_addr, csr_wdata, rsp_valid, rsp_rdata, rdr_valid, rdr_pc} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got ren=%b wen=%b addr=%h wdata=%h rsp=%b rdata=%h rdr=%b pc=%h, want all 0",
               csr_ren, csr_wen, csr_addr, csr_wdata, rsp_valid, rsp_rdata, rdr_valid, rdr_pc);
    end
  endtask

  task automatic test_csrrw();
    do_req(4'd0, A_MSCRATCH, 64'h5, 64'h8000_0000);
    do_req(4'd0, A_MSCRATCH, 64'hDEAD, 64'h8000_0004);
    compared++;
    if (csrf[A_MSCRATCH] !== 64'hDEAD) begin
      mismatched++;
      $display("FAIL csrrw_mscratch: got %h, want %h", csrf[A_MSCRATCH], 64'hDEAD);
    end
  endtask

  task automatic test_csrrs_rc();
    do_req(4'd0, A_MSTATUS, 64'h1800, 64'h8000_0008);
    do_req(4'd1, A_MSTATUS, 64'h0, 64'h8000_000C);
    do_req(4'd0, A_MSTATUS, 64'h1808, 64'h8000_0010);
    do_req(4'd2, A_MSTATUS, 64'h8, 64'h8000_0014);
    compared++;
    if (csrf[A_MSTATUS] !== 64'h1800) begin
      mismatched++;
      $display("FAIL csrrc_mstatus: got %h, want %h", csrf[A_MSTATUS], 64'h1800);
    end
    do_req(4'd0, A_MCAUSE, 64'h0, 64'h8000_0018);
  endtask

  task automatic test_ecall();
    do_req(4'd0, A_MTVEC, 64'h8000_0101, 64'h8000_0000);
    do_req(4'd0, A_MSTATUS, 64'h1808, 64'h8000_0004);
    do_req(4'd0, A_MEPC, 64'h0, 64'h8000_0008);
    do_req(4'd3, 12'h0, 64'h0, 64'h8000_0010);
    compared++;
    if ({csrf[A_MEPC], csrf[A_MCAUSE], csrf[A_MSTATUS]} !== {64'h8000_0010, 64'd11, 64'h1880}) begin
      mismatched++;
      $display("FAIL ecall_csrs: got mepc=%h mcause=%h mstatus=%h, want 80000010/b/1880",
               csrf[A_MEPC], csrf[A_MCAUSE], csrf[A_MSTATUS]);
    end
  endtask

  task automatic test_mret();
    do_req(4'd0, A_MEPC, 64'h8000_0014, 64'h8000_0020);
    do_req(4'd4, 12'h0, 64'h0, 64'h8000_0024);
    compared++;
    if (csrf[A_MSTATUS] !== 64'h1888) begin
      mismatched++;
      $display("FAIL mret_mstatus: got %h, want %h", csrf[A_MSTATUS], 64'h1888);
    end
  endtask

  task automatic test_interrupt();
    int wr_cnt, rsp_cnt, rdr_cyc;
    logic [63:0] got_pc, got_rd, old_scratch;
    do_req(4'd0, A_MSTATUS, 64'h1808, 64'h8000_0030);
    old_scratch = ref_csr[A_MSCRATCH];
    req_valid = 1'b1; req_op = 4'd0; req_addr = A_MSCRATCH; req_src = 64'h77;
    req_pc = 64'h8000_0034; intr_pc = 64'h8000_0203; mtip = 1'b1; mtie = 1'b1;
    #1;
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL intr_ready_blocked: got %b, want 0", req_ready);
    end
    wr_cnt = 0; rsp_cnt = 0; rdr_cyc = 0; got_pc = 64'd0;
    for (int c = 1; c <= 4; c++) begin
      step(); #1;
      if (csr_wen) wr_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (rdr_valid) begin rdr_cyc = c; got_pc = rdr_pc; end
    end
    compared++;
    if (wr_cnt !== 3 || rsp_cnt !== 0 || rdr_cyc !== 4 || got_pc !== 64'h8000_0100) begin
      mismatched++;
      $display("FAIL intr_sequence: got writes=%0d rsp=%0d redirect_cyc=%0d pc=%h, want 3/0/4/80000100",
               wr_cnt, rsp_cnt, rdr_cyc, got_pc);
    end
    compared++;
    if ({csrf[A_MEPC], csrf[A_MCAUSE], csrf[A_MSTATUS], csrf[A_MSCRATCH]} !==
        {64'h8000_0200, 64'h8000_0000_0000_0007, 64'h1880, old_scratch}) begin
      mismatched++;
      $display("FAIL intr_csrs: got mepc=%h mcause=%h mstatus=%h mscratch=%h, want 80000200/8000000000000007/1880/%h",
               csrf[A_MEPC], csrf[A_MCAUSE], csrf[A_MSTATUS], csrf[A_MSCRATCH], old_scratch);
    end
    // MIE is now clear, so the held request is taken despite mtip
    step(); #1;
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL intr_ready_return: got %b, want 1", req_ready);
    end
    step(); req_valid = 1'b0; #1;
    got_rd = rsp_rdata;
    compared++;
    if (rsp_valid !== 1'b1 || got_rd !== old_scratch) begin
      mismatched++;
      $display("FAIL intr_held_request: got rsp=%b rdata=%h, want 1 %h", rsp_valid, got_rd, old_scratch);
    end
    step(); mtip = 1'b0; mtie = 1'b0; #1;
    ref_csr[A_MEPC] = 64'h8000_0200;
    ref_csr[A_MCAUSE] = 64'h8000_0000_0000_0007;
    ref_csr[A_MSTATUS] = 64'h1880;
    ref_csr[A_MSCRATCH] = 64'h77;
    compared++;
    if (csrf[A_MSCRATCH] !== 64'h77) begin
      mismatched++;
      $display("FAIL intr_held_write: got %h, want %h", csrf[A_MSCRATCH], 64'h77);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_req(4'd0, A_MSTATUS, 64'h1808, 64'h8000_0040);
    do_req(4'd0, A_MCAUSE, 64'h1234, 64'h8000_0044);
    req_valid = 1'b1; req_op = 4'd3; req_pc = 64'h8000_0026; #1;
    step(); req_valid = 1'b0; #1;     // T_EPC
    step();                          // T_CAUSE
    rst = 1'b1; #1;
    compared++;
    if (csr_wen !== 1'b0 || rdr_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: got wen=%b rdr=%b rsp=%b, want 0", csr_wen, rdr_valid, rsp_valid);
    end
    step(); rst = 1'b0; #1;
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_idle: got ready=%b, want 1", req_ready);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (csr_wen || rdr_valid || rsp_valid) bad++;
      step(); #1;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL rst_mid_quiet: got %0d active cycles, want 0", bad);
    end
    compared++;
    if ({csrf[A_MEPC], csrf[A_MCAUSE], csrf[A_MSTATUS]} !== {64'h8000_0024, 64'h1234, 64'h1808}) begin
      mismatched++;
      $display("FAIL rst_mid_csrs: got mepc=%h mcause=%h mstatus=%h, want 80000024/1234/1808",
               csrf[A_MEPC], csrf[A_MCAUSE], csrf[A_MSTATUS]);
    end
    ref_csr[A_MEPC] = 64'h8000_0024;
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic [63:0] src;
    int k;
    for (int i = 0; i < 60; i++) begin
      k   = $urandom_range(0, 7);
      op  = (k < 5) ? 4'(k) : 4'($urandom_range(5, 15));
      src = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      do_req(op, alist[$urandom_range(0, 4)], src, {$urandom, $urandom});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_csrrw();
    test_csrrs_rc();
    test_ecall();
    test_mret();
    test_interrupt();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
